// File: rtl/except_issue_pkg.sv
// Shared definitions for the CP0 exception-issue block: excepttype codes, info-word layout
// and sequencing FSM states.
package except_issue_pkg;

  localparam int unsigned EXCEPT_WD   = 44;
  localparam int unsigned IdxDs       = 43;
  localparam int unsigned IdxWe       = 42;
  localparam int unsigned WaddrLsb    = 37;
  localparam int unsigned RaddrLsb    = 32;
  localparam int unsigned NumExcTypes = 9;

  localparam logic [31:0] ExcInterrupt   = 32'h0000_0001;
  localparam logic [31:0] ExcPcAssert    = 32'h0000_0002;
  localparam logic [31:0] ExcLoadAssert  = 32'h0000_0004;
  localparam logic [31:0] ExcStoreAssert = 32'h0000_0008;
  localparam logic [31:0] ExcSyscall     = 32'h0000_0010;
  localparam logic [31:0] ExcBreak       = 32'h0000_0020;
  localparam logic [31:0] ExcInvalidInst = 32'h0000_0040;
  localparam logic [31:0] ExcOv          = 32'h0000_0080;
  localparam logic [31:0] ExcEret        = 32'h0000_0100;

  // Bit positions inside the raw 8-bit flag vector.
  localparam int unsigned FlagAdelIf = 0;
  localparam int unsigned FlagRi     = 1;
  localparam int unsigned FlagSys    = 2;
  localparam int unsigned FlagBrk    = 3;
  localparam int unsigned FlagOv     = 4;
  localparam int unsigned FlagAdelLd = 5;
  localparam int unsigned FlagAdes   = 6;
  localparam int unsigned FlagEret   = 7;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRedirect
  } state_e;

  function automatic logic [EXCEPT_WD-1:0] pack_info(input logic        ds,
                                                     input logic        we,
                                                     input logic [4:0]  waddr,
                                                     input logic [4:0]  raddr,
                                                     input logic [31:0] et);
    return {ds, we, waddr, raddr, et};
  endfunction

endpackage

// File: rtl/except_issue_if.sv
// Bundle, CP0 and fetch-redirect signals of except_issue; master is the block itself,
// slave is the surrounding pipeline/CP0/IF environment.
interface except_issue_if;
  import except_issue_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          pc_i1, pc_i2;
  logic                 ds_i1, ds_i2;
  logic [7:0]           exc_i1, exc_i2;
  logic                 mtc0_i1, mtc0_i2;
  logic                 mfc0_i1, mfc0_i2;
  logic [4:0]           cp0addr_i1, cp0addr_i2;
  logic [31:0]          badaddr_i1, badaddr_i2;
  logic [EXCEPT_WD-1:0] exceptinfo_o1, exceptinfo_o2;
  logic [31:0]          pc_o1, pc_o2;
  logic [31:0]          badaddr_o1, badaddr_o2;
  logic                 to_be_flushed;
  logic [31:0]          new_pc;
  logic                 flush_o;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 if_ready;

  modport master (
    input  in_valid, pc_i1, pc_i2, ds_i1, ds_i2, exc_i1, exc_i2, mtc0_i1, mtc0_i2,
           mfc0_i1, mfc0_i2, cp0addr_i1, cp0addr_i2, badaddr_i1, badaddr_i2,
           to_be_flushed, new_pc, if_ready,
    output in_ready, exceptinfo_o1, exceptinfo_o2, pc_o1, pc_o2, badaddr_o1, badaddr_o2,
           flush_o, redirect_valid, redirect_pc
  );

  modport slave (
    output in_valid, pc_i1, pc_i2, ds_i1, ds_i2, exc_i1, exc_i2, mtc0_i1, mtc0_i2,
           mfc0_i1, mfc0_i2, cp0addr_i1, cp0addr_i2, badaddr_i1, badaddr_i2,
           to_be_flushed, new_pc, if_ready,
    input  in_ready, exceptinfo_o1, exceptinfo_o2, pc_o1, pc_o2, badaddr_o1, badaddr_o2,
           flush_o, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/except_prio_enc.sv
// Per-slot priority encoder: raw exception flags to one-hot excepttype (0 when none).
module except_prio_enc
  import except_issue_pkg::*;
(
  input  logic [7:0]  flags_i,
  output logic [31:0] excepttype_o
);

  always_comb begin
    excepttype_o = '0;
    if      (flags_i[FlagAdelIf]) excepttype_o = ExcPcAssert;
    else if (flags_i[FlagRi])     excepttype_o = ExcInvalidInst;
    else if (flags_i[FlagSys])    excepttype_o = ExcSyscall;
    else if (flags_i[FlagBrk])    excepttype_o = ExcBreak;
    else if (flags_i[FlagOv])     excepttype_o = ExcOv;
    else if (flags_i[FlagAdelLd]) excepttype_o = ExcLoadAssert;
    else if (flags_i[FlagAdes])   excepttype_o = ExcStoreAssert;
    else if (flags_i[FlagEret])   excepttype_o = ExcEret;
  end

endmodule

// File: rtl/except_issue.sv
// MEM/WB-side CP0 exception issue: encodes and registers per-slot info words, then sequences
// flush and fetch redirect. Optional per-type flush statistics under EXCEPT_STAT_EN.
module except_issue
  import except_issue_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  except_issue_if.master eif
`ifdef EXCEPT_STAT_EN
  ,
  input  logic [3:0]     stat_sel,
  output logic [15:0]    stat_cnt
`endif
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CntW-1:0] FlushLast = CntW'(FLUSH_CYCLES - 1);

  logic [31:0]          et1, et2;
  logic [EXCEPT_WD-1:0] word1, word2;
  logic                 load;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [31:0]          rpc_q, rpc_d;

  logic                 valid_q;
  logic [EXCEPT_WD-1:0] info1_q, info2_q;
  logic [31:0]          pc1_q, pc2_q, bad1_q, bad2_q;

  except_prio_enc u_enc1 (
    .flags_i      (eif.exc_i1),
    .excepttype_o (et1)
  );

  except_prio_enc u_enc2 (
    .flags_i      (eif.exc_i2),
    .excepttype_o (et2)
  );

  always_comb begin
    word1 = pack_info(eif.ds_i1, eif.mtc0_i1 && (et1 == '0),
                      eif.mtc0_i1 ? eif.cp0addr_i1 : 5'd0,
                      eif.mfc0_i1 ? eif.cp0addr_i1 : 5'd0, et1);
    word2 = pack_info(eif.ds_i2, eif.mtc0_i2 && (et2 == '0),
                      eif.mtc0_i2 ? eif.cp0addr_i2 : 5'd0,
                      eif.mfc0_i2 ? eif.cp0addr_i2 : 5'd0, et2);
    // Any older-slot exception (ERET included) kills the younger slot entirely.
    if (et1 != '0) word2 = '0;
  end

  assign eif.in_ready = (state_q == StIdle) && !eif.to_be_flushed;
  assign load         = eif.in_ready && eif.in_valid;

  // A flush request in any state (including a late interrupt) restarts the flush window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpc_d   = rpc_q;
    if (eif.to_be_flushed) begin
      state_d = StFlush;
      cnt_d   = '0;
      rpc_d   = eif.new_pc;
    end else begin
      unique case (state_q)
        StIdle: ;
        StFlush: begin
          if (cnt_q == FlushLast) begin
            state_d = StRedirect;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRedirect: if (eif.if_ready) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rpc_q   <= '0;
      valid_q <= 1'b0;
      info1_q <= '0;
      info2_q <= '0;
      pc1_q   <= '0;
      pc2_q   <= '0;
      bad1_q  <= '0;
      bad2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpc_q   <= rpc_d;
      valid_q <= load;
      if (load) begin
        info1_q <= word1;
        info2_q <= word2;
        pc1_q   <= eif.pc_i1;
        pc2_q   <= eif.pc_i2;
        bad1_q  <= eif.badaddr_i1;
        bad2_q  <= eif.badaddr_i2;
      end
    end
  end

  assign eif.exceptinfo_o1  = valid_q ? info1_q : '0;
  assign eif.exceptinfo_o2  = valid_q ? info2_q : '0;
  assign eif.pc_o1          = valid_q ? pc1_q : '0;
  assign eif.pc_o2          = valid_q ? pc2_q : '0;
  assign eif.badaddr_o1     = valid_q ? bad1_q : '0;
  assign eif.badaddr_o2     = valid_q ? bad2_q : '0;
  assign eif.flush_o        = (state_q == StFlush);
  assign eif.redirect_valid = (state_q == StRedirect);
  assign eif.redirect_pc    = (state_q == StRedirect) ? rpc_q : '0;

`ifdef EXCEPT_STAT_EN
  logic [NumExcTypes-1:0] pres_et;
  logic [15:0]            stat_q [NumExcTypes];

  // Slot 2 is only non-zero when slot 1 is clean, so at most one type is presented.
  assign pres_et = (eif.exceptinfo_o1[31:0] != '0) ? eif.exceptinfo_o1[NumExcTypes-1:0]
                                                   : eif.exceptinfo_o2[NumExcTypes-1:0];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumExcTypes; i++) begin
      if (!rst) begin
        stat_q[i] <= '0;
      end else if (eif.to_be_flushed && pres_et[i] && (stat_q[i] != 16'hffff)) begin
        stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NumExcTypes; i++) begin
      if (stat_sel == 4'(i)) stat_cnt = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_except_issue.sv
// Bench for except_issue: two instances (FLUSH_CYCLES 1 and 3) share stimulus and are checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_except_issue;
  import except_issue_pkg::*;

  localparam logic [31:0] ExcVector  = 32'hbfc0_0380;
  localparam logic [31:0] EretTarget = 32'h8000_1000;
  localparam logic [31:0] CodeTab [8] = '{32'h2, 32'h40, 32'h10, 32'h20,
                                          32'h80, 32'h4, 32'h8, 32'h100};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, irq, if_rdy, chk_en;
  logic [31:0] pc1, pc2, bad1, bad2;
  logic        ds1, ds2, mt1, mt2, mf1, mf2;
  logic [7:0]  exc1, exc2;
  logic [4:0]  ad1, ad2;
  int          n_chk = 0;
  int          n_fail = 0;

  except_issue_if bus_a ();
  except_issue_if bus_b ();

  assign bus_a.in_valid   = in_valid;    assign bus_b.in_valid   = in_valid;
  assign bus_a.pc_i1      = pc1;         assign bus_b.pc_i1      = pc1;
  assign bus_a.pc_i2      = pc2;         assign bus_b.pc_i2      = pc2;
  assign bus_a.ds_i1      = ds1;         assign bus_b.ds_i1      = ds1;
  assign bus_a.ds_i2      = ds2;         assign bus_b.ds_i2      = ds2;
  assign bus_a.exc_i1     = exc1;        assign bus_b.exc_i1     = exc1;
  assign bus_a.exc_i2     = exc2;        assign bus_b.exc_i2     = exc2;
  assign bus_a.mtc0_i1    = mt1;         assign bus_b.mtc0_i1    = mt1;
  assign bus_a.mtc0_i2    = mt2;         assign bus_b.mtc0_i2    = mt2;
  assign bus_a.mfc0_i1    = mf1;         assign bus_b.mfc0_i1    = mf1;
  assign bus_a.mfc0_i2    = mf2;         assign bus_b.mfc0_i2    = mf2;
  assign bus_a.cp0addr_i1 = ad1;         assign bus_b.cp0addr_i1 = ad1;
  assign bus_a.cp0addr_i2 = ad2;         assign bus_b.cp0addr_i2 = ad2;
  assign bus_a.badaddr_i1 = bad1;        assign bus_b.badaddr_i1 = bad1;
  assign bus_a.badaddr_i2 = bad2;        assign bus_b.badaddr_i2 = bad2;
  assign bus_a.if_ready   = if_rdy;      assign bus_b.if_ready   = if_rdy;

  // CP0 stub: flush on any presented exception or injected interrupt.
  assign bus_a.to_be_flushed = irq || (bus_a.exceptinfo_o1[31:0] != 0) ||
                               (bus_a.exceptinfo_o2[31:0] != 0);
  assign bus_b.to_be_flushed = irq || (bus_b.exceptinfo_o1[31:0] != 0) ||
                               (bus_b.exceptinfo_o2[31:0] != 0);
  assign bus_a.new_pc = (bus_a.exceptinfo_o1[31:0] == ExcEret ||
                         bus_a.exceptinfo_o2[31:0] == ExcEret) ? EretTarget : ExcVector;
  assign bus_b.new_pc = (bus_b.exceptinfo_o1[31:0] == ExcEret ||
                         bus_b.exceptinfo_o2[31:0] == ExcEret) ? EretTarget : ExcVector;

`ifdef EXCEPT_STAT_EN
  logic [3:0]  stat_sel = 4'd0;
  logic [15:0] stat_cnt_a, stat_cnt_b;
`endif

  except_issue #(.FLUSH_CYCLES(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .eif (bus_a)
`ifdef EXCEPT_STAT_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt_a)
`endif
  );

  except_issue #(.FLUSH_CYCLES(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .eif (bus_b)
`ifdef EXCEPT_STAT_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt_b)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          fc [2] = '{1, 3};
  int          m_left [2] = '{0, 0};
  bit          m_redir [2] = '{0, 0};
  logic [31:0] m_target [2];
  logic [43:0] m_i1 [2], m_i2 [2];
  logic [31:0] m_p1 [2], m_p2 [2], m_b1 [2], m_b2 [2];

  function automatic logic [31:0] m_enc(input logic [7:0] f);
    for (int i = 0; i < 8; i++) if (f[i]) return CodeTab[i];
    return 32'h0;
  endfunction

  function automatic logic [43:0] m_word(input logic ds, input logic [7:0] f, input logic mt,
                                         input logic mf, input logic [4:0] a);
    logic [31:0] et;
    et = m_enc(f);
    return {ds, mt && (et == 0), mt ? a : 5'd0, mf ? a : 5'd0, et};
  endfunction

  function automatic bit m_tbf(input int k);
    return irq || (m_i1[k][31:0] != 0) || (m_i2[k][31:0] != 0);
  endfunction

  task automatic m_step(input int k);
    bit          tbf, acc;
    logic [31:0] npc;
    if (!rst) begin
      m_left[k] = 0; m_redir[k] = 0; m_target[k] = 0;
      m_i1[k] = 0; m_i2[k] = 0; m_p1[k] = 0; m_p2[k] = 0; m_b1[k] = 0; m_b2[k] = 0;
      return;
    end
    tbf = m_tbf(k);
    npc = (m_i1[k][31:0] == 32'h100 || m_i2[k][31:0] == 32'h100) ? EretTarget : ExcVector;
    acc = (m_left[k] == 0) && !m_redir[k] && !tbf && in_valid;
    if (acc) begin
      m_i1[k] = m_word(ds1, exc1, mt1, mf1, ad1);
      m_i2[k] = (m_enc(exc1) != 0) ? 44'h0 : m_word(ds2, exc2, mt2, mf2, ad2);
      m_p1[k] = pc1; m_p2[k] = pc2; m_b1[k] = bad1; m_b2[k] = bad2;
    end else begin
      m_i1[k] = 0; m_i2[k] = 0; m_p1[k] = 0; m_p2[k] = 0; m_b1[k] = 0; m_b2[k] = 0;
    end
    if (tbf) begin
      m_left[k] = fc[k]; m_redir[k] = 1; m_target[k] = npc;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
    end else if (m_redir[k] && if_rdy) begin
      m_redir[k] = 0;
    end
  endtask

  task automatic cmp(input int k, input logic fl, input logic rv, input logic [31:0] rpc,
                     input logic ir, input logic [43:0] i1, input logic [43:0] i2,
                     input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] b1,
                     input logic [31:0] b2);
    bit rvx;
    rvx = m_redir[k] && (m_left[k] == 0);
    chk($sformatf("flush_o[%0d]", k), fl, m_left[k] > 0);
    chk($sformatf("redirect_valid[%0d]", k), rv, rvx);
    chk($sformatf("redirect_pc[%0d]", k), rpc, rvx ? m_target[k] : 32'h0);
    chk($sformatf("in_ready[%0d]", k), ir, (m_left[k] == 0) && !m_redir[k] && !m_tbf(k));
    chk($sformatf("exceptinfo_o1[%0d]", k), i1, m_i1[k]);
    chk($sformatf("exceptinfo_o2[%0d]", k), i2, m_i2[k]);
    chk($sformatf("pc_o1[%0d]", k), p1, m_p1[k]);
    chk($sformatf("pc_o2[%0d]", k), p2, m_p2[k]);
    chk($sformatf("badaddr_o1[%0d]", k), b1, m_b1[k]);
    chk($sformatf("badaddr_o2[%0d]", k), b2, m_b2[k]);
  endtask

  // Compare then advance: inputs only change just after posedge, so negedge sees final values.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, bus_a.flush_o, bus_a.redirect_valid, bus_a.redirect_pc, bus_a.in_ready,
          bus_a.exceptinfo_o1, bus_a.exceptinfo_o2, bus_a.pc_o1, bus_a.pc_o2,
          bus_a.badaddr_o1, bus_a.badaddr_o2);
      cmp(1, bus_b.flush_o, bus_b.redirect_valid, bus_b.redirect_pc, bus_b.in_ready,
          bus_b.exceptinfo_o1, bus_b.exceptinfo_o2, bus_b.pc_o1, bus_b.pc_o2,
          bus_b.badaddr_o1, bus_b.badaddr_o2);
    end
    m_step(0);
    m_step(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bundle();
    pc1 = 0; pc2 = 0; bad1 = 0; bad2 = 0; ds1 = 0; ds2 = 0;
    exc1 = 0; exc2 = 0; mt1 = 0; mt2 = 0; mf1 = 0; mf2 = 0; ad1 = 0; ad2 = 0;
  endtask

  // Present the bundle once both instances are ready; returns in cycle E+1.
  task automatic send();
    int n;
    n = 0;
    while (!(bus_a.in_ready && bus_b.in_ready) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int fl, rv, busy_rdy;
    rst = 1'b0; in_valid = 1'b0; irq = 1'b0; if_rdy = 1'b1; chk_en = 1'b0;
    clr_bundle();
    repeat (2) tick();
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // Reset state and model pins
    chk("rst_flush_a", bus_a.flush_o, 1'b0);
    chk("rst_redirect_b", bus_b.redirect_valid, 1'b0);
    chk("rst_info_a", bus_a.exceptinfo_o1, 44'h0);
    chk("rst_in_ready_b", bus_b.in_ready, 1'b1);
    chk("model_enc_11", m_enc(8'h11), 32'h2);
    chk("model_enc_80", m_enc(8'h80), 32'h100);

    // Syscall: short flush on A; on B flush 3 cycles and redirect held 5 cycles
    clr_bundle(); exc1 = 8'h04; pc1 = 32'hbfc0_0100; if_rdy = 1'b0;
    send();
    chk("t1_et1_a", bus_a.exceptinfo_o1[31:0], 32'h10);
    chk("t1_o2_a", bus_a.exceptinfo_o2, 44'h0);
    chk("t1_pc_a", bus_a.pc_o1, 32'hbfc0_0100);
    chk("t1_et1_b", bus_b.exceptinfo_o1[31:0], 32'h10);
    fl = 0; rv = 0; busy_rdy = 0;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (c == 2) begin
        chk("t1_flush_a", bus_a.flush_o, 1'b1);
        chk("t1_info_cleared_a", bus_a.exceptinfo_o1, 44'h0);
      end
      if (c == 3) begin
        chk("t1_flush_end_a", bus_a.flush_o, 1'b0);
        chk("t1_rv_a", bus_a.redirect_valid, 1'b1);
        chk("t1_rpc_a", bus_a.redirect_pc, 32'hbfc0_0380);
      end
      if (c == 6) chk("t1_rpc_held_a", bus_a.redirect_pc, 32'hbfc0_0380);
      fl += int'(bus_b.flush_o);
      rv += int'(bus_b.redirect_valid);
      if ((bus_b.flush_o || bus_b.redirect_valid) && bus_b.in_ready) busy_rdy++;
      if (bus_b.redirect_valid && rv == 5) if_rdy = 1'b1;
    end
    chk("t4_flush_cycles_b", fl, 3);
    chk("t4_redirect_cycles_b", rv, 5);
    chk("t4_in_ready_busy_b", busy_rdy, 0);

    // Priority and younger-slot kill
    clr_bundle(); exc1 = 8'h11; exc2 = 8'h10; pc2 = 32'h8000_0104;
    send();
    chk("t2_prio_a", bus_a.exceptinfo_o1[31:0], 32'h2);
    chk("t2_kill_a", bus_a.exceptinfo_o2, 44'h0);
    clr_bundle(); exc2 = 8'h10; pc2 = 32'h8000_0204;
    send();
    chk("t2_ov2_a", bus_a.exceptinfo_o2[31:0], 32'h80);
    chk("t2_o1_clean_a", bus_a.exceptinfo_o1, 44'h0);
    chk("t2_pc2_a", bus_a.pc_o2, 32'h8000_0204);
    clr_bundle(); exc1 = 8'h20; bad1 = 32'h1234_5679;
    send();
    chk("t2_adel_ld_a", bus_a.exceptinfo_o1[31:0], 32'h4);
    chk("t2_bad_a", bus_a.badaddr_o1, 32'h1234_5679);

    // CP0 access fields
    clr_bundle(); exc1 = 8'h02; mt1 = 1'b1; ad1 = 5'd12;
    send();
    chk("t3_ri_we_a", bus_a.exceptinfo_o1[42:37], 6'b0_01100);
    chk("t3_ri_et_a", bus_a.exceptinfo_o1[31:0], 32'h40);
    clr_bundle(); mt1 = 1'b1; ad1 = 5'd12; mf2 = 1'b1; ad2 = 5'd9; ds2 = 1'b1;
    send();
    chk("t3_mtc0_a", bus_a.exceptinfo_o1[42:37], 6'b1_01100);
    chk("t3_ds2_a", bus_a.exceptinfo_o2[43], 1'b1);
    chk("t3_raddr2_a", bus_a.exceptinfo_o2[36:32], 5'd9);
    chk("t3_no_flush_a", bus_a.in_ready, 1'b1);

    // ERET redirect overridden by an interrupt during REDIRECT
    clr_bundle(); exc1 = 8'h80; if_rdy = 1'b0;
    send();
    chk("t5_eret_a", bus_a.exceptinfo_o1[31:0], 32'h100);
    repeat (2) tick();
    chk("t5_eret_rpc_a", bus_a.redirect_pc, 32'h8000_1000);
    repeat (2) tick();
    chk("t5_eret_rpc_b", bus_b.redirect_pc, 32'h8000_1000);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    chk("t5_reflush_a", bus_a.flush_o, 1'b1);
    tick();
    chk("t5_irq_rv_a", bus_a.redirect_valid, 1'b1);
    chk("t5_irq_rpc_a", bus_a.redirect_pc, 32'hbfc0_0380);
    repeat (2) tick();
    chk("t5_irq_rpc_b", bus_b.redirect_pc, 32'hbfc0_0380);
    if_rdy = 1'b1;
    repeat (3) tick();

    // Reset in the middle of a flush
    clr_bundle(); exc1 = 8'h04;
    send();
    tick();
    chk("t6_flush_b", bus_b.flush_o, 1'b1);
    rst = 1'b0;
    tick();
    chk("t6_rst_flush_b", bus_b.flush_o, 1'b0);
    chk("t6_rst_rv_a", bus_a.redirect_valid, 1'b0);
    chk("t6_rst_rpc_a", bus_a.redirect_pc, 32'h0);
    chk("t6_rst_info_b", bus_b.exceptinfo_o1, 44'h0);
    rst = 1'b1;
    tick();

`ifdef EXCEPT_STAT_EN
    clr_bundle(); exc1 = 8'h04;
    send();
    send();
    repeat (8) tick();
    stat_sel = 4'd4;
    #1;
    chk("stat_sys_a", stat_cnt_a, 16'd2);
    chk("stat_sys_b", stat_cnt_b, 16'd2);
    stat_sel = 4'd7;
    #1;
    chk("stat_ov_a", stat_cnt_a, 16'd0);
`endif

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/except_issue.md
# except_issue
Initiator side of the CP0 exception interface in the dual-issue MIPS pipeline; sits at the MEM/WB boundary.
- Per slot: collects raw exception flags and CP0 access requests, priority-encodes them, packs the 44-bit exception-info words and registers them for CP0.
- Takes CP0's flush/new-PC answer and sequences the pipeline flush and the fetch redirect handshake.
## Interface
- EXCEPT_WD, 44, exception-info width: {is_delayslot[43], we[42], waddr[41:37], raddr[36:32], excepttype[31:0]}
- FLUSH_CYCLES, 1, cycles flush_o is held (≥1)
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  MEM bundle valid
- in_ready  out  1  bundle accepted this cycle
- pc_i1, pc_i2  in  32  slot PCs (i1 older)
- ds_i1, ds_i2  in  1  slot is in a delay slot
- exc_i1, exc_i2  in  8  raw flags {eret, ades, adel_ld, ov, brk, sys, ri, adel_if}
- mtc0_i1, mtc0_i2 / mfc0_i1, mfc0_i2  in  1  CP0 write/read request
- cp0addr_i1, cp0addr_i2  in  5  CP0 register number
- badaddr_i1, badaddr_i2  in  32  data address for AdEL/AdES
- exceptinfo_o1, exceptinfo_o2  out  EXCEPT_WD  to CP0
- pc_o1, pc_o2, badaddr_o1, badaddr_o2  out  32  registered companions
- to_be_flushed  in  1  CP0 flush request (combinational from exceptinfo_o*)
- new_pc  in  32  CP0 target
- flush_o  out  1  flush all stages
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  fetch target
- if_ready  in  1  IF accepts redirect
## Operation
- Slot encode, highest first: adel_if→PCASSERT, ri→INVALIDINST, sys→SYSCALL, brk→BREAK, ov→OV, adel_ld→LOADASSERT, ades→STOREASSERT, eret→ERET; none→0.
- excepttype codes, one-hot: INTERRUPT 0x1, PCASSERT 0x2, LOADASSERT 0x4, STOREASSERT 0x8, SYSCALL 0x10, BREAK 0x20, INVALIDINST 0x40, OV 0x80, ERET 0x100.
- we = mtc0 & excepttype==0; raddr = mfc0 ? cp0addr : 0; waddr = mtc0 ? cp0addr : 0.
- If slot 1 excepttype≠0, the whole exceptinfo_o2 is forced to 0 (younger slot killed); for ERET too.
- Stage register holds valid plus both words; every field is 0 when not valid.
- FSM IDLE→FLUSH on to_be_flushed; FLUSH→REDIRECT after FLUSH_CYCLES; REDIRECT→IDLE when if_ready; new_pc captured on entry to FLUSH.
- in_ready = state==IDLE & ~to_be_flushed; register loads {in_valid, encoded words} when in_ready, else clears.
- to_be_flushed asserted in FLUSH/REDIRECT (interrupt): recapture new_pc, restart FLUSH count.
## Timing
- Reset (rst=0 at edge): state IDLE, register cleared, all outputs 0, flush counter 0.
- Bundle accepted at edge E → exceptinfo_o* valid in cycle E+1; CP0 answers same cycle.
- to_be_flushed in cycle E+1 → flush_o=1 for cycles E+2..E+1+FLUSH_CYCLES; exceptinfo_o* =0 from E+2 (no double trigger).
- redirect_valid=1 from E+2+FLUSH_CYCLES, redirect_pc stable until cycle with if_ready=1; deasserted the following cycle.
- if_ready during FLUSH ignored; redirect and flush_o never overlap.
- rst low mid-sequence: next cycle IDLE, redirect dropped.
## Configuration
- EXCEPT_STAT_EN defined: 9 saturating 16-bit counters, one per excepttype, incremented when that type is presented with to_be_flushed; read via extra ports stat_sel (in 4) / stat_cnt (out 16, combinational), cleared by reset. Undefined: ports and counters absent.
## Structure
- Shared package: excepttype constants, EXCEPT_WD, field offsets, FSM state encoding.
- Sub-module except_prio_enc: combinational per-slot flag→excepttype encoder, instantiated twice.
## Test plan
- Slot 1 flags 0x04 (sys), pc_i1=0xbfc00100, ds_i1=0 → exceptinfo_o1[31:0]=0x10, o2=0; CP0 flush with new_pc=0xbfc00380 → flush_o 1 cycle, then redirect_pc=0xbfc00380 held until if_ready.
- Slot 1 flags 0x11 (adel_if+ov) → excepttype 0x2; slot 2 ov only with slot 1 clean → exceptinfo_o2[31:0]=0x80.
- Slot 1 mtc0 addr 12 with ri → we=0, excepttype 0x40; clean mtc0 addr 12 → bits[42:37]=6'b1_01100.
- FLUSH_CYCLES=3, if_ready held low 4 cycles → flush_o 3 cycles, redirect_valid 5 cycles, in_ready=0 throughout.
- to_be_flushed during REDIRECT with new_pc=0xbfc00380 after eret target 0x80001000 → restart FLUSH, final redirect_pc=0xbfc00380.
- rst low during FLUSH → all outputs 0 next cycle; with EXCEPT_STAT_EN, two syscall flushes → stat_cnt(SYSCALL)=2.
